// File: rtl/merlin_busarb_pkg.sv
// Shared constants and types for the two-to-one memory bus arbiter.
// Latency: n/a (types, owner tags, state encodings, instruction size).
// Backpressure: n/a.
package merlin_busarb_pkg;

    // Owner tag stored per accepted request
    localparam logic RV_BUSARB_TAG_I = 1'b0;
    localparam logic RV_BUSARB_TAG_D = 1'b1;

    // Instruction fetches are always full-word reads
    localparam logic [1:0] RV_BUSARB_ISIZE = 2'b10;

    typedef enum logic [1:0] {
        RV_BUSARB_ARB    = 2'd0,
        RV_BUSARB_LOCK_I = 2'd1,
        RV_BUSARB_LOCK_D = 2'd2
    } busarb_state_t;

    // Next-state for a grant that was offered but not taken by memory
    function automatic busarb_state_t lock_state(input logic tag);
        return (tag == RV_BUSARB_TAG_D) ? RV_BUSARB_LOCK_D : RV_BUSARB_LOCK_I;
    endfunction

endpackage

// File: rtl/merlin_busarb_tagfifo.sv
// In-order owner-tag FIFO, 1 bit wide, depth 2^C_OUTSTANDING_X.
// Latency: push visible at head next cycle; head tag is read combinationally.
// Backpressure: full/empty from registered count only; callers must respect them.
module merlin_busarb_tagfifo #(
    parameter int C_OUTSTANDING_X = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic tag_i,
    output logic tag_o,
    output logic full_o,
    output logic empty_o
);
    localparam int DEPTH = 1 << C_OUTSTANDING_X;

    logic [DEPTH-1:0]           mem_q,  mem_d;
    logic [C_OUTSTANDING_X-1:0] wptr_q, wptr_d;
    logic [C_OUTSTANDING_X-1:0] rptr_q, rptr_d;
    logic [C_OUTSTANDING_X:0]   cnt_q,  cnt_d;
    logic                       do_push, do_pop;

    assign full_o  = (cnt_q == {1'b1, {C_OUTSTANDING_X{1'b0}}});
    assign empty_o = (cnt_q == '0);
    assign tag_o   = mem_q[rptr_q];

    // Pointer, count and storage update; simultaneous push/pop leaves count unchanged
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = tag_i;
            wptr_d        = wptr_q + C_OUTSTANDING_X'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + C_OUTSTANDING_X'(1);
        end
        cnt_d = cnt_q + {{C_OUTSTANDING_X{1'b0}}, do_push}
                      - {{C_OUTSTANDING_X{1'b0}}, do_pop};
    end

    // Registered FIFO state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/merlin_busarb.sv
// Two-to-one (instruction/data) memory bus arbiter with in-order response routing.
// Latency: zero added on request and response paths (combinational); state updates next cycle.
// Backpressure: an offered-but-stalled grant locks to its port; full tag FIFO blocks new requests.
// Option: define RV_BUSARB_RR_EN for round-robin; otherwise data port has fixed priority.
module merlin_busarb
    import merlin_busarb_pkg::*;
#(
    parameter int C_OUTSTANDING_X = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqwrite_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,
    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqsize_o,
    output logic        mreqwrite_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,
    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i,
    output logic        spurious_o
);
    busarb_state_t state_q, state_d;
    logic          fifo_full, fifo_empty, fifo_head;
    logic          grant_vld, grant_tag;
    logic          accept, pop;
    logic          both_tag;

`ifdef RV_BUSARB_RR_EN
    logic last_q, last_d;

    // Both requesting: favour the port that lost the last accepted request
    assign both_tag = ~last_q;
    assign last_d   = accept ? grant_tag : last_q;

    // Round-robin history; reset value makes D win the first tie
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) last_q <= RV_BUSARB_TAG_I;
        else         last_q <= last_d;
    end
`else
    assign both_tag = RV_BUSARB_TAG_D;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= RV_BUSARB_ARB;
        else         state_q <= state_d;
    end

    // FSM next state: lock onto a stalled grant, release on accept
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RV_BUSARB_ARB:    if (mreqvalid_o && !mreqready_i) state_d = lock_state(grant_tag);
            RV_BUSARB_LOCK_I,
            RV_BUSARB_LOCK_D: if (accept) state_d = RV_BUSARB_ARB;
            default:          state_d = RV_BUSARB_ARB;
        endcase
    end

    // FSM outputs: grant selection (nothing granted in reset or with the FIFO full in ARB)
    always_comb begin
        grant_vld = 1'b0;
        grant_tag = RV_BUSARB_TAG_D;
        if (!reset_i) begin
            unique case (state_q)
                RV_BUSARB_ARB: if (!fifo_full) begin
                    if (ireqvalid_i && dreqvalid_i) begin
                        grant_vld = 1'b1;
                        grant_tag = both_tag;
                    end else if (dreqvalid_i) begin
                        grant_vld = 1'b1;
                        grant_tag = RV_BUSARB_TAG_D;
                    end else if (ireqvalid_i) begin
                        grant_vld = 1'b1;
                        grant_tag = RV_BUSARB_TAG_I;
                    end
                end
                RV_BUSARB_LOCK_I: begin
                    grant_vld = 1'b1;
                    grant_tag = RV_BUSARB_TAG_I;
                end
                RV_BUSARB_LOCK_D: begin
                    grant_vld = 1'b1;
                    grant_tag = RV_BUSARB_TAG_D;
                end
                default: grant_vld = 1'b0;
            endcase
        end
    end

    // Request mux: granted port's payload, instruction fields forced, zero when idle
    always_comb begin
        mreqvalid_o = 1'b0;
        mreqsize_o  = '0;
        mreqwrite_o = 1'b0;
        mreqhpl_o   = '0;
        mreqaddr_o  = '0;
        mreqdata_o  = '0;
        if (grant_vld && grant_tag == RV_BUSARB_TAG_D) begin
            mreqvalid_o = dreqvalid_i && !fifo_full;
            mreqsize_o  = dreqsize_i;
            mreqwrite_o = dreqwrite_i;
            mreqhpl_o   = dreqhpl_i;
            mreqaddr_o  = dreqaddr_i;
            mreqdata_o  = dreqdata_i;
        end else if (grant_vld) begin
            mreqvalid_o = ireqvalid_i && !fifo_full;
            mreqsize_o  = RV_BUSARB_ISIZE;
            mreqhpl_o   = ireqhpl_i;
            mreqaddr_o  = ireqaddr_i;
        end
        accept      = mreqvalid_o && mreqready_i;
        ireqready_o = grant_vld && (grant_tag == RV_BUSARB_TAG_I) && mreqready_i && !fifo_full;
        dreqready_o = grant_vld && (grant_tag == RV_BUSARB_TAG_D) && mreqready_i && !fifo_full;
    end

    // Response routing by head tag; beats with nothing outstanding are swallowed
    always_comb begin
        irspvalid_o = !reset_i && mrspvalid_i && !fifo_empty && (fifo_head == RV_BUSARB_TAG_I);
        drspvalid_o = !reset_i && mrspvalid_i && !fifo_empty && (fifo_head == RV_BUSARB_TAG_D);
        spurious_o  = !reset_i && mrspvalid_i && fifo_empty;
        if (reset_i)         mrspready_o = 1'b0;
        else if (fifo_empty) mrspready_o = 1'b1;
        else                 mrspready_o = (fifo_head == RV_BUSARB_TAG_D) ? drspready_i : irspready_i;
        pop         = mrspvalid_i && mrspready_o && !fifo_empty;
        irsprerr_o  = mrsprerr_i;
        irspdata_o  = mrspdata_i;
        drsprerr_o  = mrsprerr_i;
        drspwerr_o  = mrspwerr_i;
        drspdata_o  = mrspdata_i;
    end

    merlin_busarb_tagfifo #(
        .C_OUTSTANDING_X (C_OUTSTANDING_X)
    ) u_tagfifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept),
        .pop_i   (pop),
        .tag_i   (grant_tag),
        .tag_o   (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_merlin_busarb.sv
// Directed self-checking bench for merlin_busarb (C_OUTSTANDING_X = 2).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived constants; tie-break order depends on RV_BUSARB_RR_EN.
module tb_merlin_busarb;
    logic        clk_i, reset_i;
    logic        ireqready_o, ireqvalid_i, irspready_i, irspvalid_o, irsprerr_o;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i, irspdata_o;
    logic        dreqready_o, dreqvalid_i, dreqwrite_i, drspready_i;
    logic        drspvalid_o, drsprerr_o, drspwerr_o;
    logic [1:0]  dreqsize_i, dreqhpl_i;
    logic [31:0] dreqaddr_i, dreqdata_i, drspdata_o;
    logic        mreqready_i, mreqvalid_o, mreqwrite_o, mrspready_o;
    logic [1:0]  mreqsize_o, mreqhpl_o;
    logic [31:0] mreqaddr_o, mreqdata_o;
    logic        mrspvalid_i, mrsprerr_i, mrspwerr_i, spurious_o;
    logic [31:0] mrspdata_i;

    int checks = 0;
    int failures = 0;
    logic        exp_tag [4];
    logic [31:0] rsp_dat [4];

    merlin_busarb #(.C_OUTSTANDING_X(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
        .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
        .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
        .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i),
        .dreqwrite_i(dreqwrite_i), .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i),
        .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
        .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
        .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqsize_o(mreqsize_o),
        .mreqwrite_o(mreqwrite_o), .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o),
        .mreqdata_o(mreqdata_o), .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i),
        .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i), .mrspdata_i(mrspdata_i),
        .spurious_o(spurious_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // ---------------- reset state, with inputs active to prove gating
        reset_i = 1'b1;
        ireqvalid_i = 1'b1; ireqhpl_i = 2'd3; ireqaddr_i = 32'h55; irspready_i = 1'b1;
        dreqvalid_i = 1'b1; dreqsize_i = 2'd0; dreqwrite_i = 1'b1; dreqhpl_i = 2'd1;
        dreqaddr_i = 32'h66; dreqdata_i = 32'h77; drspready_i = 1'b1;
        mreqready_i = 1'b1; mrspvalid_i = 1'b1; mrsprerr_i = 1'b0; mrspwerr_i = 1'b0;
        mrspdata_i = 32'h0;
        tick(); tick();
        chk("rst_mreqvalid", mreqvalid_o, 0);
        chk("rst_ireqready", ireqready_o, 0);
        chk("rst_dreqready", dreqready_o, 0);
        chk("rst_mreqaddr", mreqaddr_o, 0);
        chk("rst_mreqdata", mreqdata_o, 0);
        chk("rst_mrspready", mrspready_o, 0);
        chk("rst_spurious", spurious_o, 0);
        chk("rst_rspvalid", {irspvalid_o, drspvalid_o}, 0);
        reset_i = 1'b0; mrspvalid_i = 1'b0;
        ireqaddr_i = 32'h10; dreqaddr_i = 32'h20; dreqwrite_i = 1'b0;

        // ---------------- simultaneous requests, 4 accepts fill the FIFO
`ifdef RV_BUSARB_RR_EN
        exp_tag[0] = 1'b1; exp_tag[1] = 1'b0; exp_tag[2] = 1'b1; exp_tag[3] = 1'b0;
`else
        exp_tag[0] = 1'b1; exp_tag[1] = 1'b1; exp_tag[2] = 1'b1; exp_tag[3] = 1'b1;
`endif
        rsp_dat[0] = 32'hA0; rsp_dat[1] = 32'hB0; rsp_dat[2] = 32'hC0; rsp_dat[3] = 32'hD0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sim_addr%0d", k), mreqaddr_o, exp_tag[k] ? 32'h20 : 32'h10);
            chk($sformatf("sim_drdy%0d", k), dreqready_o, exp_tag[k]);
            chk($sformatf("sim_irdy%0d", k), ireqready_o, !exp_tag[k]);
            tick();
        end
        chk("sim_full_mreqvalid", mreqvalid_o, 0);
        chk("sim_full_readies", {ireqready_o, dreqready_o}, 0);
        ireqvalid_i = 1'b0; dreqvalid_i = 1'b0;
        mrspvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mrspdata_i = rsp_dat[k];
            #1;
            chk($sformatf("rsp_dvld%0d", k), drspvalid_o, exp_tag[k]);
            chk($sformatf("rsp_ivld%0d", k), irspvalid_o, !exp_tag[k]);
            chk($sformatf("rsp_data%0d", k), exp_tag[k] ? drspdata_o : irspdata_o, rsp_dat[k]);
            tick();
        end
        mrspvalid_i = 1'b0;

        // ---------------- backpressure lock on I, D arrives a cycle later
        mreqready_i = 1'b0;
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h100;
        dreqsize_i = 2'd0; dreqwrite_i = 1'b1; dreqaddr_i = 32'h200; dreqdata_i = 32'hDEAD;
        #1;
        chk("lk_addr0", mreqaddr_o, 32'h100);
        chk("lk_mvalid0", mreqvalid_o, 1);
        chk("lk_isize", mreqsize_o, 2'b10);
        chk("lk_iwrite", mreqwrite_o, 0);
        tick();
        dreqvalid_i = 1'b1;
        #1;
        chk("lk_addr1", mreqaddr_o, 32'h100);
        chk("lk_idata", mreqdata_o, 0);
        tick();
        chk("lk_addr2", mreqaddr_o, 32'h100);
        chk("lk_drdy2", dreqready_o, 0);
        tick();
        mreqready_i = 1'b1;
        #1;
        chk("lk_addr3", mreqaddr_o, 32'h100);
        chk("lk_irdy3", ireqready_o, 1);
        chk("lk_drdy3", dreqready_o, 0);
        tick();
        ireqvalid_i = 1'b0;
        #1;
        chk("lk_daddr", mreqaddr_o, 32'h200);
        chk("lk_ddata", mreqdata_o, 32'hDEAD);
        chk("lk_dwrite", mreqwrite_o, 1);
        chk("lk_drdy", dreqready_o, 1);
        tick();
        dreqvalid_i = 1'b0;

        // ---------------- responses: head I, then D with sink backpressure
        mrspvalid_i = 1'b1; mrspdata_i = 32'h11; irspready_i = 1'b1; drspready_i = 1'b0;
        #1;
        chk("rb_ivld", irspvalid_o, 1);
        chk("rb_idata", irspdata_o, 32'h11);
        chk("rb_mrdy_i", mrspready_o, 1);
        tick();
        chk("rb_dvld_stall", drspvalid_o, 1);
        chk("rb_mrdy_stall", mrspready_o, 0);
        tick();
        chk("rb_dvld_held", drspvalid_o, 1);
        chk("rb_ivld_held", irspvalid_o, 0);
        drspready_i = 1'b1; mrspwerr_i = 1'b1;
        #1;
        chk("rb_mrdy_go", mrspready_o, 1);
        chk("rb_dwerr", drspwerr_o, 1);
        tick();
        mrspwerr_i = 1'b0;

        // ---------------- spurious response on an empty FIFO
        #1;
        chk("sp_mrdy", mrspready_o, 1);
        chk("sp_pulse", spurious_o, 1);
        chk("sp_rspvalid", {irspvalid_o, drspvalid_o}, 0);
        tick();
        mrspvalid_i = 1'b0;
        #1;
        chk("sp_clear", spurious_o, 0);

        // ---------------- full FIFO blocks, pop frees a slot next cycle
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h300;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fu_irdy%0d", k), ireqready_o, 1);
            tick();
        end
        chk("fu_block", mreqvalid_o, 0);
        mrspvalid_i = 1'b1;
        #1;
        chk("fu_nobypass", mreqvalid_o, 0);
        chk("fu_pop_ivld", irspvalid_o, 1);
        tick();
        mrspvalid_i = 1'b0;
        #1;
        chk("fu_free_mvalid", mreqvalid_o, 1);
        chk("fu_free_irdy", ireqready_o, 1);
        tick();

        // ---------------- reset mid-flight with requests outstanding
        reset_i = 1'b1;
        #1;
        chk("mr_mreqvalid", mreqvalid_o, 0);
        chk("mr_readies", {ireqready_o, dreqready_o, mrspready_o}, 0);
        chk("mr_mreqaddr", mreqaddr_o, 0);
        #1;
        reset_i = 1'b0; ireqvalid_i = 1'b0;
        tick();
        mrspvalid_i = 1'b1;
        #1;
        chk("mr_spurious", spurious_o, 1);
        chk("mr_ivld", irspvalid_o, 0);
        chk("mr_mrdy", mrspready_o, 1);
        tick();
        mrspvalid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
